// File: rtl/renkon_ctrl_linebuf_pkg.sv
// Shared constants, state encoding and width helpers for the renkon line-buffer sequencer.
package renkon_ctrl_linebuf_pkg;

    localparam int RENKON_DWIDTH  = 16;
    localparam int RENKON_BUFSIZE = 8;
    localparam int RENKON_HWIDTH  = 10;
    localparam int RENKON_FSIZE   = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A single line buffer still needs a 1-bit index to keep port widths legal.
    function automatic int line_width(input int lines);
        return (clog2(lines) > 0) ? clog2(lines) : 1;
    endfunction

endpackage

// File: rtl/renkon_ctrl_linebuf.sv
// Writes a raster stream circularly into FSIZE line buffers and, once enough rows are
// resident, marks each column read as a vertical slice for the window/MAC datapath.
module renkon_ctrl_linebuf
    import renkon_ctrl_linebuf_pkg::*;
#(
    parameter int DWIDTH  = RENKON_DWIDTH,
    parameter int BUFSIZE = RENKON_BUFSIZE,
    parameter int HWIDTH  = RENKON_HWIDTH,
    parameter int FSIZE   = RENKON_FSIZE,
    localparam int LWIDTH = line_width(FSIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [BUFSIZE:0]   img_w,
    input  logic [HWIDTH-1:0]  img_h,
    input  logic               in_valid,
    input  logic [DWIDTH-1:0]  in_data,
    output logic               in_ready,
    output logic [FSIZE-1:0]   mem_we,
    output logic [BUFSIZE-1:0] mem_addr,
    output logic [DWIDTH-1:0]  write_data,
    output logic [LWIDTH-1:0]  top_line,
    output logic               slice_valid,
    output logic [BUFSIZE-1:0] slice_col,
    output logic               slice_last,
    output logic               ack
);

    state_t              state_reg, state_next;
    logic [BUFSIZE:0]    img_w_reg;
    logic [HWIDTH-1:0]   img_h_reg, row_reg;
    logic [BUFSIZE-1:0]  col_reg;
    logic [LWIDTH-1:0]   wr_line_reg, wr_line_inc;
    logic                accept, col_last, row_last, img_last, rd_en;
    logic [FSIZE-1:0]    mem_we_next, mem_we_reg;
    logic [BUFSIZE-1:0]  mem_addr_reg, slice_col_reg;
    logic [DWIDTH-1:0]   write_data_reg;
    logic                rd_issue_reg, wr_last_reg, slice_valid_reg, slice_last_reg;
    logic [LWIDTH-1:0]   rd_top_reg, top_line_reg;

    // Input closes the cycle after the final pixel so nothing of the next image slips in.
    assign in_ready    = ((state_reg == ST_FILL) || (state_reg == ST_STREAM)) && !wr_last_reg;
    assign accept      = in_valid && in_ready;
    assign col_last    = ({1'b0, col_reg} == (img_w_reg - (BUFSIZE+1)'(1)));
    assign row_last    = (row_reg == (img_h_reg - HWIDTH'(1)));
    assign img_last    = col_last && row_last;
    assign rd_en       = accept && (row_reg >= HWIDTH'(FSIZE - 1));
    assign wr_line_inc = (wr_line_reg == LWIDTH'(FSIZE - 1)) ? '0 : wr_line_reg + LWIDTH'(1);

    genvar gi;
    generate
        for (gi = 0; gi < FSIZE; gi++) begin : g_we
            assign mem_we_next[gi] = accept && (wr_line_reg == LWIDTH'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:   if (req) state_next = ST_FILL;
            ST_FILL:   if (accept && col_last && (row_reg == HWIDTH'(FSIZE - 2))) state_next = ST_STREAM;
            ST_STREAM: if (wr_last_reg) state_next = ST_FLUSH;
            ST_FLUSH:  state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            img_w_reg       <= '0;
            img_h_reg       <= '0;
            col_reg         <= '0;
            row_reg         <= '0;
            wr_line_reg     <= '0;
            mem_we_reg      <= '0;
            mem_addr_reg    <= '0;
            write_data_reg  <= '0;
            rd_issue_reg    <= 1'b0;
            rd_top_reg      <= '0;
            wr_last_reg     <= 1'b0;
            slice_valid_reg <= 1'b0;
            slice_col_reg   <= '0;
            slice_last_reg  <= 1'b0;
            top_line_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && req) begin
                img_w_reg   <= img_w;
                img_h_reg   <= img_h;
                col_reg     <= '0;
                row_reg     <= '0;
                wr_line_reg <= '0;
            end else if (accept) begin
                if (col_last) begin
                    col_reg     <= '0;
                    row_reg     <= row_reg + HWIDTH'(1);
                    wr_line_reg <= wr_line_inc;
                end else begin
                    col_reg <= col_reg + BUFSIZE'(1);
                end
            end

            // Stage 1: write (and, once primed, read) all lines at the current column.
            mem_we_reg   <= mem_we_next;
            rd_issue_reg <= rd_en;
            wr_last_reg  <= accept && img_last;
            if (accept) begin
                mem_addr_reg   <= col_reg;
                write_data_reg <= in_data;
            end
            if (rd_en) begin
                rd_top_reg <= wr_line_inc;
            end

            // Stage 2: memory read data is now on the line-buffer outputs.
            slice_valid_reg <= rd_issue_reg;
            slice_last_reg  <= wr_last_reg;
            if (rd_issue_reg) begin
                slice_col_reg <= mem_addr_reg;
                top_line_reg  <= rd_top_reg;
            end
        end
    end

    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign write_data  = write_data_reg;
    assign top_line    = top_line_reg;
    assign slice_valid = slice_valid_reg;
    assign slice_col   = slice_col_reg;
    assign slice_last  = slice_last_reg;
    assign ack         = (state_reg == ST_DONE);

endmodule

// File: tb/tb_renkon_ctrl_linebuf.sv
// Randomized bench for renkon_ctrl_linebuf: an image-level model predicts every write,
// slice (with the data a write-first line-buffer bank returns) and the completion pulse.
module tb_renkon_ctrl_linebuf;

    localparam int DW = 16;
    localparam int BS = 3;
    localparam int HW = 10;
    localparam int FS = 3;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst, req, in_valid;
    logic [BS:0]   img_w;
    logic [HW-1:0] img_h;
    logic [DW-1:0] in_data;
    logic          in_ready, slice_valid, slice_last, ack;
    logic [FS-1:0] mem_we;
    logic [BS-1:0] mem_addr, slice_col;
    logic [DW-1:0] write_data;
    logic [LW-1:0] top_line;

    renkon_ctrl_linebuf #(.DWIDTH(DW), .BUFSIZE(BS), .HWIDTH(HW), .FSIZE(FS)) dut (
        .clk(clk), .rst(rst), .req(req), .img_w(img_w), .img_h(img_h),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .write_data(write_data),
        .top_line(top_line), .slice_valid(slice_valid), .slice_col(slice_col),
        .slice_last(slice_last), .ack(ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line-buffer bank: registered address, write-first.
    logic [DW-1:0] lb_mem [FS][1 << BS];
    logic [BS-1:0] lb_addr_q;
    always @(posedge clk) begin
        for (int i = 0; i < FS; i++) begin
            if (mem_we[i]) lb_mem[i][mem_addr] <= write_data;
        end
        lb_addr_q <= mem_addr;
    end

    typedef struct {
        int            due;
        logic [FS-1:0] we;
        logic [BS-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    typedef struct {
        int              due;
        logic [BS-1:0]   col;
        logic [LW-1:0]   top;
        logic            last;
        logic [FS*DW-1:0] data;
    } sl_exp_t;

    wr_exp_t       wq[$];
    sl_exp_t       sq[$];
    logic [DW-1:0] pix [16][8];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            ack_due = -1;
    int            slice_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({in_ready, mem_we, mem_addr, write_data, top_line,
                    slice_valid, slice_col, slice_last, ack});
    endfunction

    always @(negedge clk) begin
        wr_exp_t          we_e;
        sl_exp_t          se;
        logic [FS*DW-1:0] rd_slice;
        while (wq.size() > 0 && wq[0].due < cyc) begin
            chk("wr_missing", 64'(wq[0].due), 64'(cyc));
            we_e = wq.pop_front();
        end
        while (sq.size() > 0 && sq[0].due < cyc) begin
            chk("slice_missing", 64'(sq[0].due), 64'(cyc));
            se = sq.pop_front();
        end
        if (mem_we != '0) begin
            if (wq.size() == 0) begin
                chk("wr_spurious", 64'(mem_we), 64'(0));
            end else begin
                we_e = wq.pop_front();
                chk("wr_cycle", 64'(cyc), 64'(we_e.due));
                chk("mem_we", 64'(mem_we), 64'(we_e.we));
                chk("mem_addr", 64'(mem_addr), 64'(we_e.addr));
                chk("write_data", 64'(write_data), 64'(we_e.data));
            end
        end
        if (slice_valid) begin
            slice_cnt++;
            if (sq.size() == 0) begin
                chk("slice_spurious", 64'(slice_valid), 64'(0));
            end else begin
                se = sq.pop_front();
                chk("slice_cycle", 64'(cyc), 64'(se.due));
                chk("slice_col", 64'(slice_col), 64'(se.col));
                chk("top_line", 64'(top_line), 64'(se.top));
                chk("slice_last", 64'(slice_last), 64'(se.last));
                for (int k = 0; k < FS; k++) begin
                    rd_slice[k*DW +: DW] = lb_mem[(int'(se.top) + k) % FS][lb_addr_q];
                end
                chk("slice_data", 64'(rd_slice), 64'(se.data));
            end
        end else if (slice_last) begin
            chk("slice_last_alone", 64'(slice_last), 64'(0));
        end
        if (ack || cyc == ack_due) begin
            chk("ack", 64'(ack), 64'(cyc == ack_due));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // mode 0: back-to-back pixels 1,2,3..; mode 1: valid every other cycle;
    // mode 2: random bubbles, random data and stray req pulses.
    task automatic run_image(input int w, input int h, input int mode, input int abort_row);
        int               r = 0;
        int               c = 0;
        int               n = 0;
        int               t = 0;
        bit               v;
        bit               last;
        sl_exp_t          se;
        wr_exp_t          we_e;
        img_w     = (BS+1)'(w);
        img_h     = HW'(h);
        req       = 1'b1;
        in_valid  = 1'b0;
        slice_cnt = 0;
        step();
        req = 1'b0;
        while (r < h) begin
            chk("in_ready_run", 64'(in_ready), 64'(1));
            if (r == abort_row && c == 1) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                while (wq.size() > 0 && wq[$].due > cyc) we_e = wq.pop_back();
                while (sq.size() > 0 && sq[$].due > cyc) se = sq.pop_back();
                step();
                chk("abort_outs", all_outs(), 64'(0));
                rst = 1'b0;
                $display("image %0dx%0d mode %0d aborted at row %0d", w, h, mode, r);
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (t % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 2) begin
                req   = ($urandom_range(0, 7) == 0);
                img_w = (BS+1)'($urandom_range(1, 8));
                img_h = HW'($urandom_range(3, 9));
            end
            if (v) begin
                in_valid = 1'b1;
                in_data  = (mode == 0) ? DW'(n + 1) : DW'($urandom);
                pix[r][c] = in_data;
                last = (r == h - 1) && (c == w - 1);
                wq.push_back('{due: cyc + 1, we: FS'(1) << (r % FS), addr: BS'(c), data: in_data});
                if (r >= FS - 1) begin
                    se.due  = cyc + 2;
                    se.col  = BS'(c);
                    se.top  = LW'((r + 1) % FS);
                    se.last = last;
                    for (int k = 0; k < FS; k++) se.data[k*DW +: DW] = pix[r - FS + 1 + k][c];
                    sq.push_back(se);
                end
                if (last) ack_due = cyc + 3;
                n++;
                c++;
                if (c == w) begin
                    c = 0;
                    r++;
                end
            end else begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
            end
            t++;
            step();
        end
        in_valid = 1'b0;
        req      = 1'b0;
        chk("in_ready_end", 64'(in_ready), 64'(0));
        repeat (3) step();
        chk("slice_count", 64'(slice_cnt), 64'((h - FS + 1) * w));
        chk("idle_ready", 64'(in_ready), 64'(0));
        $display("image %0dx%0d mode %0d: %0d pixels, %0d slices", w, h, mode, n, slice_cnt);
    endtask

    initial begin
        rst      = 1'b1;
        req      = 1'b1;
        img_w    = 4;
        img_h    = 4;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) step();
        chk("reset_outs", all_outs(), 64'(0));
        rst = 1'b0;
        req = 1'b0;
        step();
        run_image(4, 4, 0, -1);
        run_image(4, 4, 1, -1);
        run_image(1, 5, 2, -1);
        run_image(4, 4, 2, 2);
        run_image(8, 3, 0, -1);
        for (int i = 0; i < 6; i++) begin
            run_image($urandom_range(1, 8), $urandom_range(3, 6), 2, -1);
        end
        repeat (3) step();
        chk("wr_queue_left", 64'(wq.size()), 64'(0));
        chk("slice_queue_left", 64'(sq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/renkon_ctrl_linebuf.md
Name: renkon_ctrl_linebuf

Overview:
- Sequencer for a bank of FSIZE line-buffer memories. Each memory is one image row deep, with single-port write, a registered address and 1-cycle read latency; a write and a read of the same address in the same cycle return the new data.
- Accepts a raster pixel stream and writes each row into the lines circularly.
- Once FSIZE rows are resident, reads every column across all lines to give the convolution datapath a vertical FSIZE-pixel slice per column, with the rotation index needed to order the lines.
- Sits between the input DMA stream and the renkon window/MAC datapath.

Parameters:
- DWIDTH, 16, pixel data width.
- BUFSIZE, 8, line-buffer address width; max image width = 2**BUFSIZE.
- HWIDTH, 10, row-count width.
- FSIZE, 5, filter height = number of line buffers.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  1  start pulse; sampled only in IDLE.
- img_w  in  BUFSIZE+1  row width in pixels, 1..2**BUFSIZE; latched on req.
- img_h  in  HWIDTH  row count, >= FSIZE; latched on req.
- in_valid  in  1  input pixel valid.
- in_data  in  DWIDTH  input pixel.
- in_ready  out  1  accepting pixels.
- mem_we  out  FSIZE  one-hot write enable per line buffer.
- mem_addr  out  BUFSIZE  shared address to all line buffers.
- write_data  out  DWIDTH  data to line buffers (registered copy of in_data).
- top_line  out  clog2(FSIZE)  index of the line holding the oldest row of the current slice.
- slice_valid  out  1  line-buffer read_data outputs hold a valid column slice this cycle.
- slice_col  out  BUFSIZE  column index of the current slice.
- slice_last  out  1  final slice of the image.
- ack  out  1  one-cycle completion pulse.

Behaviour:
- Reset state: all outputs 0, state IDLE, all counters 0. The line-buffer contents are not cleared.
- States and transitions:
  - IDLE: in_ready=0. On req, latch img_w/img_h, clear counters, go to FILL.
  - FILL: in_ready=1. Stays here while row < FSIZE-1.
  - STREAM: in_ready=1.
  - FLUSH: one cycle, waits out the memory latency, then goes to DONE.
  - DONE: ack=1 for exactly 1 cycle, then IDLE.
- Each accepted pixel (in_valid & in_ready), registered by 1 cycle:
  - mem_we = onehot(wr_line); mem_addr = col; write_data = in_data.
  - Then col++. At col == img_w-1: col = 0, row++, wr_line = (wr_line+1) mod FSIZE.
- Read issue: when an accepted pixel has row >= FSIZE-1, the same write cycle is also a read of all lines at that address.
  - One cycle after the write: slice_valid=1 and slice_col = that column.
  - top_line = (wr_line_of_that_pixel + 1) mod FSIZE.
- Transition FILL->STREAM happens on the last pixel of row FSIZE-2.
- On the last pixel of row img_h-1, in_ready drops the next cycle and the state goes to FLUSH.
  - slice_last and slice_valid are high together in the FLUSH cycle.
- No pixel accepted (in_valid=0): no write, no slice, counters hold. Bubbles are allowed anywhere.
- Totals:
  - Slices per image = (img_h-FSIZE+1)*img_w.
  - Latency from accepted pixel to its slice = 2 cycles: 1 register + 1 memory.
- Boundaries:
  - img_w=1: every pixel wraps the row.
  - wr_line wraps FSIZE-1 -> 0.
  - req outside IDLE is ignored.
  - rst mid-operation: next cycle is IDLE with all outputs 0, and any in-flight slice is dropped.
  - img_w=0 or img_h<FSIZE: undefined; the bench does not drive these values.

Decomposition:
- Shared package/header (with ninjin/renkon constants): BUFSIZE, DWIDTH, FSIZE, HWIDTH, state encodings (IDLE, FILL, STREAM, FLUSH, DONE), and a clog2 function.
- No sub-module: a single FSM plus counters. The line buffers themselves are instantiated by the parent.

Test Plan (FSIZE=3, BUFSIZE=3 unless noted):
- Reset with req held high → all outputs 0. After rst falls, one req with img_w=4, img_h=4 → FILL, with in_ready=1 one cycle later.
- First 8 pixels (rows 0-1, values 1..8) streamed back-to-back:
  - mem_we = 001 for 4 cycles, then 010.
  - mem_addr = 0,1,2,3,0,…
  - slice_valid stays 0.
- Pixel 9 (row 2, col 0) → two cycles later slice_valid=1, slice_col=0, top_line=0. With line buffers attached, the slice reads lines 0,1,2 = 1,5,9.
- Row 3 → writes go to line 0 (mem_we=001), top_line=1. Exactly 8 slice_valid cycles total; slice_last coincides with the 8th; ack pulses 1 cycle after.
- in_valid toggled 1,0,1,0 → writes and slices occur only on accepted cycles. Slice count is still 8 and no column is skipped.
- Assert rst during row 2 of a run → next cycle IDLE, in_ready=0, slice_valid=0. A new req with img_w=8 (max), img_h=3 yields 8 slices.
